// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: framer state encoding and frame geometry.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_W     = 32;
    localparam int UART_FRAME_BITS = 35;
    localparam int UART_IDX_W      = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus a 1->0 edge detector.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_async,
    output logic rx_sync,
    output logic rx_fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // All flops reset to the idle-high line level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_async;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_sync = sync_q;
    assign rx_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start detect, mid-bit sampling of 32 data bits, parity and stop,
// then hands {Rx_data, Rx_In} to the downstream parity checker with a Load1 strobe.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_W     = UART_DATA_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Baud_Tick,
    input  logic              Rx_Serial,
    output logic [DATA_W-1:0] Rx_data,
    output logic              Rx_In,
    output logic              Load1,
    output logic              Framing_Error,
    output logic              Rx_Busy,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0]      HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0]      FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [UART_IDX_W-1:0] IDX_LAST  = UART_IDX_W'(DATA_W - 1);
    localparam logic [UART_IDX_W-1:0] IDX_ONE   = UART_IDX_W'(1);

    logic                  line_sync;
    logic                  line_fall;
    uart_rx_state_e        state;
    logic [CNT_W-1:0]      tick_cnt;
    logic [UART_IDX_W-1:0] bit_idx;
    logic [DATA_W-1:0]     shift_q;
    logic                  parity_q;

    uart_rx_sync u_sync (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .rx_async (Rx_Serial),
        .rx_sync  (line_sync),
        .rx_fall  (line_fall)
    );

    assign dbg_state = state;

    // Load1 is a valid-only strobe with no ready: Rx_data and Rx_In are valid and new in the
    // single cycle Load1 is high and hold until the next Load1. Framing_Error never coincides.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= ST_IDLE;
            tick_cnt      <= '0;
            bit_idx       <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            Rx_data       <= '0;
            Rx_In         <= 1'b0;
            Load1         <= 1'b0;
            Framing_Error <= 1'b0;
            Rx_Busy       <= 1'b0;
        end else begin
            Load1         <= 1'b0;
            Framing_Error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Edge detect is not tick-gated so a start edge is never missed between ticks.
                    if (line_fall) begin
                        state    <= ST_START;
                        tick_cnt <= '0;
                        Rx_Busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (Baud_Tick) begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt <= '0;
                            if (!line_sync) begin
                                state   <= ST_DATA;
                                bit_idx <= '0;
                            end else begin
                                state   <= ST_IDLE;
                                Rx_Busy <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_ONE;
                        end
                    end
                end
                ST_DATA: begin
                    if (Baud_Tick) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt <= '0;
                            shift_q  <= {line_sync, shift_q[DATA_W-1:1]};
                            if (bit_idx == IDX_LAST) begin
                                state <= ST_PARITY;
                            end else begin
                                bit_idx <= bit_idx + IDX_ONE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_ONE;
                        end
                    end
                end
                ST_PARITY: begin
                    if (Baud_Tick) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt <= '0;
                            parity_q <= line_sync;
                            state    <= ST_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + CNT_ONE;
                        end
                    end
                end
                ST_STOP: begin
                    if (Baud_Tick) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt <= '0;
                            state    <= ST_IDLE;
                            Rx_Busy  <= 1'b0;
                            if (line_sync) begin
                                Rx_data <= shift_q;
                                Rx_In   <= parity_q;
                                Load1   <= 1'b1;
                            end else begin
                                Framing_Error <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    Rx_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: frame vector table, glitch, back-to-back and mid-frame reset.
module tb_uart_rx_frame;
    import uart_pkg::*;

    localparam int OS       = 16;
    localparam int TICK_DIV = 2;
    localparam int BIT_CLKS = OS * TICK_DIV;

    logic        Clk;
    logic        Rst_n;
    logic        Baud_Tick;
    logic        Rx_Serial;
    logic [31:0] Rx_data;
    logic        Rx_In;
    logic        Load1;
    logic        Framing_Error;
    logic        Rx_Busy;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int load_cnt = 0;
    int fe_cnt = 0;
    int cyc = 0;
    int tick_div = 0;
    logic load_prev = 1'b0;
    logic fe_prev = 1'b0;

    logic [32:0] exp_q[$];
    int          load_cyc_q[$];

    uart_rx_frame #(.OVERSAMPLE(OS), .DATA_W(32)) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Baud_Tick     (Baud_Tick),
        .Rx_Serial     (Rx_Serial),
        .Rx_data       (Rx_data),
        .Rx_In         (Rx_In),
        .Load1         (Load1),
        .Framing_Error (Framing_Error),
        .Rx_Busy       (Rx_Busy),
        .dbg_state     (dbg_state)
    );

    // clock / reset / tick generation
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        Baud_Tick = 1'b0;
        forever begin
            @(negedge Clk);
            tick_div  = (tick_div + 1) % TICK_DIV;
            Baud_Tick = (tick_div == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive_bit(input logic b);
        Rx_Serial = b;
        repeat (BIT_CLKS) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [31:0] d, input logic p, input logic s);
        drive_bit(1'b0);
        for (int i = 0; i < 32; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
    endtask

    // scoreboard / strobe monitor
    always @(negedge Clk) begin
        if (Load1) begin
            logic [32:0] exp;
            load_cnt++;
            load_cyc_q.push_back(cyc);
            checks++;
            if (load_prev) begin
                errors++;
                $display("FAIL load1_width: got 2+ cycles expected 1");
            end
            checks++;
            if (Framing_Error) begin
                errors++;
                $display("FAIL strobe_excl: got Load1=1 Framing_Error=1 expected exclusive");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL load_unexpected: got data %0h in %0b expected no load", Rx_data, Rx_In);
            end else begin
                exp = exp_q.pop_front();
                if ({Rx_In, Rx_data} !== exp) begin
                    errors++;
                    $display("FAIL load_data: got %0h expected %0h", {Rx_In, Rx_data}, exp);
                end
            end
        end
        if (Framing_Error) begin
            fe_cnt++;
            checks++;
            if (fe_prev) begin
                errors++;
                $display("FAIL fe_width: got 2+ cycles expected 1");
            end
        end
        load_prev = Load1;
        fe_prev   = Framing_Error;
    end

    typedef struct {
        logic [31:0] data;
        logic        par;
        logic        stop;
        int          brk_bits;
        int          exp_load;
        int          exp_fe;
        logic [31:0] exp_data;
        logic        exp_in;
        logic        exp_perr;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int l0, f0, n0;
        logic [31:0] d1, d2;

        vecs[0] = '{32'hA5A5_0F0F, 1'b0, 1'b1, 0, 1, 0, 32'hA5A5_0F0F, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0001, 1'b0, 1'b1, 0, 1, 0, 32'h0000_0001, 1'b0, 1'b1};
        vecs[2] = '{32'hDEAD_BEEF, 1'b1, 1'b0, 3, 0, 1, 32'h0000_0001, 1'b0, 1'b1};
        vecs[3] = '{32'h8000_0000, 1'b1, 1'b1, 0, 1, 0, 32'h8000_0000, 1'b1, 1'b0};

        Rst_n     = 1'b0;
        Rx_Serial = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst_rx_data", Rx_data, 32'h0);
        chk("rst_rx_in", Rx_In, 1'b0);
        chk("rst_load1", Load1, 1'b0);
        chk("rst_fe", Framing_Error, 1'b0);
        chk("rst_busy", Rx_Busy, 1'b0);
        chk("rst_state", dbg_state, ST_IDLE);
        Rst_n = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b1);

        for (int i = 0; i < 4; i++) begin
            l0 = load_cnt;
            f0 = fe_cnt;
            if (vecs[i].exp_load != 0) exp_q.push_back({vecs[i].par, vecs[i].data});
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
            if (vecs[i].brk_bits > 0) begin
                repeat (vecs[i].brk_bits) drive_bit(1'b0);
                chk($sformatf("v%0d_break_busy", i), Rx_Busy, 1'b0);
            end
            drive_bit(1'b1);
            drive_bit(1'b1);
            chk($sformatf("v%0d_load_cnt", i), load_cnt - l0, vecs[i].exp_load);
            chk($sformatf("v%0d_fe_cnt", i), fe_cnt - f0, vecs[i].exp_fe);
            chk($sformatf("v%0d_rx_data", i), Rx_data, vecs[i].exp_data);
            chk($sformatf("v%0d_rx_in", i), Rx_In, vecs[i].exp_in);
            chk($sformatf("v%0d_parity_err", i), ^{Rx_In, Rx_data}, vecs[i].exp_perr);
            chk($sformatf("v%0d_busy", i), Rx_Busy, 1'b0);
        end

        // glitch: low for 4 ticks, then high -> false start
        l0 = load_cnt;
        f0 = fe_cnt;
        Rx_Serial = 1'b0;
        repeat (4 * TICK_DIV) @(negedge Clk);
        chk("glitch_busy_hi", Rx_Busy, 1'b1);
        chk("glitch_state", dbg_state, ST_START);
        Rx_Serial = 1'b1;
        repeat (BIT_CLKS) @(negedge Clk);
        chk("glitch_busy_lo", Rx_Busy, 1'b0);
        chk("glitch_idle", dbg_state, ST_IDLE);
        chk("glitch_no_load", load_cnt - l0, 0);
        chk("glitch_no_fe", fe_cnt - f0, 0);

        // back-to-back frames with no idle gap
        d1 = 32'h1234_5678;
        d2 = 32'h8765_4321;
        l0 = load_cnt;
        n0 = load_cyc_q.size();
        exp_q.push_back({^d1, d1});
        exp_q.push_back({^d2, d2});
        send_frame(d1, ^d1, 1'b1);
        send_frame(d2, ^d2, 1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        chk("b2b_load_cnt", load_cnt - l0, 2);
        if (load_cyc_q.size() >= n0 + 2)
            chk("b2b_spacing", load_cyc_q[n0+1] - load_cyc_q[n0], 35 * BIT_CLKS);
        chk("b2b_rx_data", Rx_data, d2);
        chk("b2b_rx_in", Rx_In, ^d2);

        // reset asserted in the middle of data bit 17
        l0 = load_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 17; i++) drive_bit(1'b1);
        Rx_Serial = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge Clk);
        chk("pre_rst_busy", Rx_Busy, 1'b1);
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_rx_data", Rx_data, 32'h0);
        chk("mid_rst_rx_in", Rx_In, 1'b0);
        chk("mid_rst_load1", Load1, 1'b0);
        chk("mid_rst_fe", Framing_Error, 1'b0);
        chk("mid_rst_busy", Rx_Busy, 1'b0);
        chk("mid_rst_state", dbg_state, ST_IDLE);
        repeat (4) @(negedge Clk);
        Rst_n = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        chk("post_rst_no_load", load_cnt - l0, 0);
        exp_q.push_back({1'b0, 32'hFFFF_FFFF});
        send_frame(32'hFFFF_FFFF, 1'b0, 1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        chk("post_rst_load_cnt", load_cnt - l0, 1);
        chk("post_rst_rx_data", Rx_data, 32'hFFFF_FFFF);
        chk("post_rst_rx_in", Rx_In, 1'b0);

        chk("exp_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial receive framer for the UART receive path. Synchronises the asynchronous serial line, detects the start bit, samples 32 data bits (LSB first), one parity bit and one stop bit at mid-bit using a 16x oversampling tick. It then presents the assembled word, the received parity bit and a one-cycle load strobe directly to the downstream parity checker. Frames with a bad stop bit are dropped and flagged instead of loaded.

## Interface
Parameters:
- OVERSAMPLE, 16, Baud_Tick pulses per bit period; must be even and ≥4
- DATA_W, 32, data bits per frame; fixed at 32 to match the parity checker

Ports:
- Clk  in  1  system clock; all logic on rising edge
- Rst_n  in  1  reset, asynchronous assert, active-low
- Baud_Tick  in  1  single-cycle enable at OVERSAMPLE × baud rate
- Rx_Serial  in  1  asynchronous serial line, idle high
- Rx_data  out  32  last good frame's data, bit 0 = first data bit received
- Rx_In  out  1  last good frame's received parity bit; feeds the checker's Rx_In
- Load1  out  1  one-cycle strobe: Rx_data/Rx_In are newly valid; feeds the checker's Load1
- Framing_Error  out  1  one-cycle strobe: stop bit sampled low, frame discarded
- Rx_Busy  out  1  high in every state except IDLE

Clocking and reset: one clock; reset is asynchronous and active-low.

## Operation
- Rx_Serial passes through a 2-FF synchroniser; both flops reset to 1. A falling edge is defined as synchronised line = 0 while the previous synchronised value = 1.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: on falling edge → START, tick counter cleared.
- START: count Baud_Ticks. On the (OVERSAMPLE/2)th tick, sample the line:
  - 0 → DATA, bit index 0, tick counter cleared.
  - 1 → false start, back to IDLE.
- DATA: on every OVERSAMPLE-th tick, shift the sample into the data register, LSB first.
  - After bit index 31 is sampled → PARITY.
- PARITY: on the OVERSAMPLE-th tick, capture the sample into a parity holding flop → STOP.
- STOP: on the OVERSAMPLE-th tick, sample the line:
  - 1 → copy the shift register to Rx_data and the parity flop to Rx_In, pulse Load1, → IDLE.
  - 0 → pulse Framing_Error; Rx_data and Rx_In unchanged; → IDLE.
- Because start detection needs a 1→0 edge, a line held low (break) after a framing error produces no new frame until the line returns high.
- Parity is not evaluated here; the received bit is forwarded unchanged (even-parity convention, checked downstream).
- Rx_data and Rx_In hold their value between Load1 pulses.
- Baud_Tick low: counters and state frozen.
- Reset values: Rx_data = 0, Rx_In = 0, Load1 = 0, Framing_Error = 0, Rx_Busy = 0, state = IDLE, counters = 0.

## Timing
- Synchroniser latency: 2 Clk.
- Sample points fall at the centre of each bit: (OVERSAMPLE/2) ticks into the start bit, then every OVERSAMPLE ticks.
- Frame length: 35 bit periods (start + 32 data + parity + stop).
- Load1 / Framing_Error assert on the Clk edge following the Baud_Tick that samples the stop bit. Each is exactly 1 Clk wide, and the two are mutually exclusive.
- Rx_data and Rx_In update on the same edge Load1 rises, so the downstream checker sees a consistent triple.
- A new falling edge can be accepted from the first IDLE cycle, which gives back-to-back frames with no idle gap.
- Asserting Rst_n low mid-frame aborts immediately: all outputs return to reset values and no strobe is issued.

## Structure
- Shared package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP), OVERSAMPLE default, DATA_W = 32, FRAME_BITS = 35.
- One sub-module, uart_rx_sync: 2-FF synchroniser plus falling-edge detect. It outputs the synchronised line and a fall pulse, and is reusable by the other UART receive blocks.
- Tick counter width: $clog2(OVERSAMPLE). Bit index: 5 bits.

## Test plan
- Frame with data 32'hA5A5_0F0F and parity 0, stop 1 → one Load1 pulse; Rx_data = 32'hA5A5_0F0F; Rx_In = 0; Framing_Error stays 0.
- Data 32'h0000_0001 sent with parity 0 (wrong for even parity) → Load1 pulses and Rx_In = 0; the parity checker model raises Parity_Error. This shows the framer forwards the bit unchanged.
- Frame 32'hDEAD_BEEF with stop bit 0 → Framing_Error pulses once; no Load1; Rx_data keeps its previous value.
- Glitch: line low for 4 ticks then high → returns to IDLE from START; no strobe; Rx_Busy low again.
- Two back-to-back frames, 32'h1234_5678 then 32'h8765_4321, with no idle gap → two Load1 pulses 35 bit periods apart, each carrying the correct data.
- Rst_n asserted during data bit 17 → all outputs 0 at once. After release, a full frame 32'hFFFF_FFFF with parity 0 → Load1 with Rx_data = 32'hFFFF_FFFF.
